// File: rtl/matrix_cps_pkg.sv
// Shared types and constants of the matrix coprocessor, including the LSU row-sequencer state.
package matrix_cps_pkg;
   localparam int BUS_BYTES           = 16;
   localparam int LSU_MAX_OUTSTANDING = 2;
   localparam int LSU_REG_W           = 3;

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, PAD, DONE} lsu_seq_state_t;

   typedef struct packed {
      logic [xif_pkg::X_ID_WIDTH-1:0] id;
      logic                           is_store;
      logic [LSU_REG_W-1:0]           operand_reg;
      logic [31:0]                    addr;
      logic [31:0]                    stride;
   } lsu_instr_t;

   typedef struct packed {
      logic [7:0] n_rows;
      logic [7:0] n_col_bytes;
   } lsu_conf_t;
endpackage

// File: rtl/xif_pkg.sv
// Coprocessor-interface constants shared by the matrix coprocessor blocks.
package xif_pkg;
   localparam int X_ID_WIDTH = 4;
endpackage

// File: rtl/matrix_lsu_row_seq.sv
// LSU row sequencer: expands one load/store into one bus beat per matrix row.
// Optional MATRIX_LSU_ZERO_PAD_EN zero-fills unloaded bytes and rows on loads.
module matrix_lsu_row_seq
   import matrix_cps_pkg::*;
#(
   parameter int N_REGS          = 8,
   parameter int N_ROWS          = 4,
   parameter int BUS_WIDTH       = 128,
   parameter int ID_WIDTH        = xif_pkg::X_ID_WIDTH,
   parameter int MAX_OUTSTANDING = LSU_MAX_OUTSTANDING
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       instr_valid_i,
   output logic                       instr_ready_o,
   input  lsu_instr_t                 instr_i,
   input  lsu_conf_t                  conf_i,
   output logic                       mem_req_o,
   input  logic                       mem_gnt_i,
   output logic                       mem_we_o,
   output logic [31:0]                mem_addr_o,
   output logic [BUS_WIDTH/8-1:0]     mem_be_o,
   output logic [BUS_WIDTH-1:0]       mem_wdata_o,
   input  logic                       mem_rvalid_i,
   input  logic [BUS_WIDTH-1:0]       mem_rdata_i,
   output logic [$clog2(N_REGS)-1:0]  rf_rreg_o,
   output logic [$clog2(N_ROWS)-1:0]  rf_rrow_o,
   input  logic [BUS_WIDTH-1:0]       rf_rdata_i,
   output logic                       rf_we_o,
   output logic [$clog2(N_REGS)-1:0]  rf_wreg_o,
   output logic [$clog2(N_ROWS)-1:0]  rf_wrow_o,
   output logic [BUS_WIDTH-1:0]       rf_wdata_o,
   output logic [BUS_WIDTH/8-1:0]     rf_wbe_o,
   output logic                       done_o,
   output logic [ID_WIDTH-1:0]        done_id_o,
   output logic                       misalign_o
);
   localparam int NB     = BUS_WIDTH / 8;
   localparam int REG_W  = $clog2(N_REGS);
   localparam int ROW_W  = $clog2(N_ROWS);
   localparam int CNT_W  = ROW_W + 1;
   localparam int OFF_W  = $clog2(NB);
   localparam int BYTE_W = OFF_W + 1;
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
`ifdef MATRIX_LSU_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   lsu_seq_state_t     state;
   logic [ID_WIDTH-1:0] id;
   logic               is_store;
   logic               misal;
   logic [REG_W-1:0]   op_reg;
   logic [31:0]        addr;
   logic [31:0]        stride;
   logic [CNT_W-1:0]   rows, issue_row, resp_row, pad_row;
   logic [BYTE_W-1:0]  bytes;
   logic [OUT_W-1:0]   outstanding;
   logic               grant;
   logic [CNT_W-1:0]   rows_in;
   logic [BYTE_W-1:0]  bytes_in;
   logic               misal_in;

   function automatic logic [NB-1:0] byte_mask(input logic [BYTE_W-1:0] n);
      logic [NB-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[i] = (i < int'(n));
      return m;
   endfunction

   function automatic logic [BUS_WIDTH-1:0] mask_data(input logic [BUS_WIDTH-1:0] d,
                                                      input logic [NB-1:0] m);
      logic [BUS_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
      return r;
   endfunction

   always_comb begin
      rows_in  = (conf_i.n_rows > 8'(N_ROWS)) ? CNT_W'(N_ROWS) : CNT_W'(conf_i.n_rows);
      bytes_in = (conf_i.n_col_bytes > 8'(NB)) ? BYTE_W'(NB) : BYTE_W'(conf_i.n_col_bytes);
      misal_in = |{instr_i.addr[OFF_W-1:0], instr_i.stride[OFF_W-1:0]};
   end

   // Request only decodes registered state, so it cannot glitch off while a grant is pending.
   assign mem_req_o     = (state == ISSUE) && (outstanding < OUT_W'(MAX_OUTSTANDING));
   assign grant         = mem_req_o & mem_gnt_i;
   assign mem_we_o      = is_store;
   assign mem_addr_o    = addr;
   assign mem_be_o      = byte_mask(bytes);
   assign mem_wdata_o   = mem_req_o ? rf_rdata_i : '0;
   assign rf_rreg_o     = op_reg;
   assign rf_rrow_o     = issue_row[ROW_W-1:0];
   assign instr_ready_o = (state == IDLE);
   assign done_o        = (state == DONE);
   assign done_id_o     = done_o ? id : '0;
   assign misalign_o    = done_o & misal;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         id          <= '0;
         is_store    <= 1'b0;
         misal       <= 1'b0;
         op_reg      <= '0;
         addr        <= '0;
         stride      <= '0;
         rows        <= '0;
         bytes       <= '0;
         issue_row   <= '0;
         resp_row    <= '0;
         pad_row     <= '0;
         outstanding <= '0;
         rf_we_o     <= 1'b0;
         rf_wreg_o   <= '0;
         rf_wrow_o   <= '0;
         rf_wdata_o  <= '0;
         rf_wbe_o    <= '0;
      end else begin
         outstanding <= outstanding + OUT_W'(grant) - OUT_W'(mem_rvalid_i);
         rf_we_o     <= 1'b0;
         // Responses arrive in order, so the response count names the row being returned.
         if (mem_rvalid_i && !is_store && (state == ISSUE || state == DRAIN)) begin
            rf_we_o   <= 1'b1;
            rf_wreg_o <= op_reg;
            rf_wrow_o <= resp_row[ROW_W-1:0];
            resp_row  <= resp_row + CNT_W'(1);
            if (PAD_EN) begin
               rf_wdata_o <= mask_data(mem_rdata_i, byte_mask(bytes));
               rf_wbe_o   <= '1;
            end else begin
               rf_wdata_o <= mem_rdata_i;
               rf_wbe_o   <= byte_mask(bytes);
            end
         end
         case (state)
            IDLE: if (instr_valid_i) begin
               id        <= ID_WIDTH'(instr_i.id);
               is_store  <= instr_i.is_store;
               op_reg    <= REG_W'(instr_i.operand_reg);
               addr      <= instr_i.addr & ~32'(NB - 1);
               stride    <= instr_i.stride & ~32'(NB - 1);
               misal     <= misal_in;
               rows      <= rows_in;
               bytes     <= bytes_in;
               issue_row <= '0;
               resp_row  <= '0;
               pad_row   <= rows_in;
               if (rows_in != '0)                      state <= ISSUE;
               else if (PAD_EN && !instr_i.is_store)   state <= PAD;
               else                                    state <= DONE;
            end
            ISSUE: if (grant) begin
               addr      <= addr + stride;
               issue_row <= issue_row + CNT_W'(1);
               if (issue_row == rows - CNT_W'(1)) state <= DRAIN;
            end
            DRAIN: if (outstanding == '0) begin
               if (PAD_EN && !is_store && rows < CNT_W'(N_ROWS)) state <= PAD;
               else                                              state <= DONE;
            end
            PAD: begin
               rf_we_o    <= 1'b1;
               rf_wreg_o  <= op_reg;
               rf_wrow_o  <= pad_row[ROW_W-1:0];
               rf_wdata_o <= '0;
               rf_wbe_o   <= '1;
               pad_row    <= pad_row + CNT_W'(1);
               if (pad_row == CNT_W'(N_ROWS - 1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_lsu_row_seq.sv
// Randomized bench for matrix_lsu_row_seq with a bus/RF environment and a row-level reference model.
module tb_matrix_lsu_row_seq;
   import matrix_cps_pkg::*;

   localparam int NB = 16;
`ifdef MATRIX_LSU_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, instr_valid, instr_ready;
   lsu_instr_t    instr;
   lsu_conf_t     conf;
   logic          mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [31:0]   mem_addr;
   logic [15:0]   mem_be, rf_wbe;
   logic [127:0]  mem_wdata, mem_rdata, rf_rdata, rf_wdata;
   logic [2:0]    rf_rreg, rf_wreg;
   logic [1:0]    rf_rrow, rf_wrow;
   logic          rf_we, done, misalign;
   logic [3:0]    done_id;

   logic [127:0]  rf_mem [8][4];
   logic [127:0]  mem [logic [31:0]];
   assign rf_rdata = rf_mem[rf_rreg][rf_rrow];

   matrix_lsu_row_seq dut (
      .clk_i(clk), .rst_i(rst),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr), .conf_i(conf),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .rf_rreg_o(rf_rreg), .rf_rrow_o(rf_rrow), .rf_rdata_i(rf_rdata),
      .rf_we_o(rf_we), .rf_wreg_o(rf_wreg), .rf_wrow_o(rf_wrow), .rf_wdata_o(rf_wdata), .rf_wbe_o(rf_wbe),
      .done_o(done), .done_id_o(done_id), .misalign_o(misalign)
   );

   typedef struct { logic [127:0] d; int due; } resp_t;
   resp_t        resp_q[$];
   logic [31:0]  b_addr[$];
   logic         b_we[$];
   logic [15:0]  b_be[$];
   logic [127:0] b_wd[$];

   int n_chk = 0, n_pass = 0;
   int cyc = 0, gnt_pct = 100, resp_max = 0, stall_left = 0, out_cnt = 0, max_out = 0;
   int acc_cyc, first_gnt_cyc, last_rfw_cyc, done_cyc;
   logic hold_rv = 1'b0, done_seen = 1'b0, got_mis = 1'b0, pend = 1'b0;
   logic [3:0] got_id = '0;
   logic [31:0] pend_addr;
   logic [15:0] pend_be;
   logic [127:0] pend_wd;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [127:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'h1234_5678};
   endfunction

   function automatic lsu_instr_t mk(input logic [3:0] id, input logic st, input logic [2:0] rg,
                                     input logic [31:0] a, input logic [31:0] s);
      lsu_instr_t t;
      t.id = id; t.is_store = st; t.operand_reg = rg; t.addr = a; t.stride = s;
      return t;
   endfunction

   function automatic lsu_conf_t mkc(input int nr, input int nc);
      lsu_conf_t c;
      c.n_rows = 8'(nr); c.n_col_bytes = 8'(nc);
      return c;
   endfunction

   // One cycle of environment: observe outputs at negedge, then drive bus responses and grant.
   task automatic tick();
      resp_t r;
      logic [127:0] m;
      @(negedge clk);
      cyc++;
      if (rst) begin
         resp_q.delete(); pend = 1'b0; out_cnt = 0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
         return;
      end
      if (pend) begin
         chk("req_held", 128'(mem_req), 128'(1));
         chk("addr_stable", 128'(mem_addr), 128'(pend_addr));
         chk("be_stable", 128'(mem_be), 128'(pend_be));
         chk("wdata_stable", mem_wdata, pend_wd);
      end
      if (rf_we) begin
         for (int i = 0; i < NB; i++)
            if (rf_wbe[i]) rf_mem[rf_wreg][rf_wrow][8*i +: 8] = rf_wdata[8*i +: 8];
         last_rfw_cyc = cyc;
      end
      if (done) begin
         done_seen = 1'b1; done_cyc = cyc; got_id = done_id; got_mis = misalign;
      end
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (!hold_rv && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
         r = resp_q.pop_front();
         mem_rvalid = 1'b1; mem_rdata = r.d; out_cnt--;
      end
      if (stall_left > 0 && mem_req) begin
         mem_gnt = 1'b0; stall_left--;
      end else begin
         mem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
      end
      if (mem_req && mem_gnt) begin
         if (b_addr.size() == 0) first_gnt_cyc = cyc;
         b_addr.push_back(mem_addr); b_we.push_back(mem_we);
         b_be.push_back(mem_be); b_wd.push_back(mem_wdata);
         if (mem_we) begin
            m = mem_rd(mem_addr);
            for (int i = 0; i < NB; i++) if (mem_be[i]) m[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_addr] = m;
            r.d = {$urandom(), $urandom(), $urandom(), $urandom()};
         end else begin
            r.d = mem_rd(mem_addr);
         end
         r.due = cyc + 1 + int'($urandom_range(0, resp_max));
         resp_q.push_back(r);
         out_cnt++;
         if (out_cnt > max_out) max_out = out_cnt;
      end
      pend = mem_req && !mem_gnt;
      pend_addr = mem_addr; pend_be = mem_be; pend_wd = mem_wdata;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready"}, 128'(instr_ready), 128'(1));
      chk({tag, "_req"}, 128'(mem_req), 128'(0));
      chk({tag, "_bus"}, {63'(0), mem_we, mem_addr, mem_be}, 128'(0));
      chk({tag, "_wdata"}, mem_wdata, 128'(0));
      chk({tag, "_rfw"}, {107'(0), rf_we, rf_wreg, rf_wrow, rf_wbe}, 128'(0));
      chk({tag, "_rfdata"}, rf_wdata, 128'(0));
      chk({tag, "_done"}, {122'(0), done, done_id, misalign}, 128'(0));
   endtask

   task automatic run_txn(input lsu_instr_t in, input lsu_conf_t cf, input int hold_n);
      int rows, nb, budget;
      logic [31:0] base, strd;
      logic [16:0] bet;
      logic [15:0] be;
      logic [127:0] d;
      logic [127:0] exp_rf [4];
      logic [31:0] ea[$];
      logic [127:0] ew[$];
      rows = (cf.n_rows > 8'd4) ? 4 : int'(cf.n_rows);
      nb   = (cf.n_col_bytes > 8'd16) ? 16 : int'(cf.n_col_bytes);
      base = in.addr & ~32'hF;
      strd = in.stride & ~32'hF;
      bet  = (17'd1 << nb) - 17'd1;
      be   = bet[15:0];
      for (int r = 0; r < 4; r++) exp_rf[r] = rf_mem[in.operand_reg][r];
      for (int r = 0; r < rows; r++) begin
         ea.push_back(base + strd * 32'(r));
         ew.push_back(rf_mem[in.operand_reg][r]);
      end
      if (!in.is_store) begin
         for (int r = 0; r < 4; r++) begin
            if (r < rows) begin
               d = mem_rd(base + strd * 32'(r));
               for (int i = 0; i < NB; i++) begin
                  if (i < nb)   exp_rf[r][8*i +: 8] = d[8*i +: 8];
                  else if (PAD) exp_rf[r][8*i +: 8] = 8'h00;
               end
            end else if (PAD) begin
               exp_rf[r] = '0;
            end
         end
      end
      b_addr.delete(); b_we.delete(); b_be.delete(); b_wd.delete();
      done_seen = 1'b0; max_out = out_cnt;
      budget = 0;
      while (!instr_ready && budget < 50) begin tick(); budget++; end
      chk("ready_idle", 128'(instr_ready), 128'(1));
      instr = in; conf = cf; instr_valid = 1'b1; acc_cyc = cyc;
      tick();
      instr_valid = 1'b0;
      if (hold_n > 0) begin
         hold_rv = 1'b1;
         repeat (hold_n) tick();
         chk("gnt_limit", 128'(b_addr.size()), 128'((rows < 2) ? rows : 2));
         chk("req_blocked", 128'(mem_req), 128'(0));
         hold_rv = 1'b0;
      end
      budget = 0;
      while (!done_seen && budget < 400) begin tick(); budget++; end
      chk("done_seen", 128'(done_seen), 128'(1));
      chk("done_id", 128'(got_id), 128'(in.id));
      chk("misalign", 128'(got_mis), 128'(|((in.addr | in.stride) & 32'hF)));
      chk("n_beats", 128'(b_addr.size()), 128'(rows));
      for (int i = 0; i < rows && i < b_addr.size(); i++) begin
         chk("beat_addr", 128'(b_addr[i]), 128'(ea[i]));
         chk("beat_we", 128'(b_we[i]), 128'(in.is_store));
         chk("beat_be", 128'(b_be[i]), 128'(be));
         if (in.is_store) chk("beat_wdata", b_wd[i], ew[i]);
      end
      chk("outstanding_le2", 128'(max_out <= 2), 128'(1));
      for (int r = 0; r < 4; r++) chk("rf_row", rf_mem[in.operand_reg][r], exp_rf[r]);
      tick();
      chk("done_pulse", 128'(done), 128'(0));
   endtask

   initial begin
      int budget;
      logic [31:0] a, s;
      rst = 1'b1; instr_valid = 1'b0; instr = '0; conf = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      for (int g = 0; g < 8; g++)
         for (int r = 0; r < 4; r++) rf_mem[g][r] = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat (3) tick();
      check_reset("reset");
      rst = 1'b0;
      tick();

      // 4-row aligned load with full-rate grant and one-cycle responses.
      gnt_pct = 100; resp_max = 0;
      run_txn(mk(4'h1, 1'b0, 3'd2, 32'h1000, 32'h40), mkc(4, 16), 0);
      chk("lat_first_req", 128'(first_gnt_cyc - acc_cyc), 128'(1));
      chk("lat_last_rfw", 128'(last_rfw_cyc - acc_cyc), 128'(6));
      chk("lat_done", 128'(done_cyc - acc_cyc), 128'(7));

      // Store with row 0 stalled for three cycles.
      stall_left = 3;
      run_txn(mk(4'h2, 1'b1, 3'd5, 32'h3000, 32'h80), mkc(2, 8), 0);

      // Short load: partial rows and partial bytes.
      run_txn(mk(4'h3, 1'b0, 3'd1, 32'h1000, 32'h40), mkc(2, 4), 0);

      // Misaligned base and wrapping stride.
      run_txn(mk(4'h4, 1'b0, 3'd4, 32'h1004, 32'h40), mkc(1, 16), 0);
      run_txn(mk(4'h5, 1'b0, 3'd6, 32'h0, 32'hFFFF_FFF0), mkc(2, 16), 0);

      // Responses withheld: outstanding limit must stop requests.
      run_txn(mk(4'h6, 1'b0, 3'd7, 32'h4000, 32'h10), mkc(4, 16), 6);

      // Reset in ISSUE after one grant.
      hold_rv = 1'b1;
      budget = 0;
      while (!instr_ready && budget < 50) begin tick(); budget++; end
      b_addr.delete(); b_we.delete(); b_be.delete(); b_wd.delete();
      instr = mk(4'h7, 1'b0, 3'd0, 32'h5000, 32'h10); conf = mkc(4, 16); instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0; gnt_pct = 0;
      tick();
      chk("pre_rst_grants", 128'(b_addr.size()), 128'(1));
      rst = 1'b1;
      tick();
      check_reset("midrst");
      rst = 1'b0; hold_rv = 1'b0; gnt_pct = 100;
      tick();
      run_txn(mk(4'h8, 1'b0, 3'd0, 32'h5000, 32'h10), mkc(4, 16), 0);

      for (int k = 0; k < 40; k++) begin
         a = 32'h0000_2000 + ($urandom_range(0, 63) << 4);
         if ($urandom_range(0, 3) == 0) a[3:0] = 4'($urandom_range(1, 15));
         case ($urandom_range(0, 4))
            0:       s = 32'h10;
            1:       s = 32'h40;
            2:       s = 32'hFFFF_FFF0;
            3:       s = 32'h0;
            default: s = $urandom();
         endcase
         gnt_pct    = int'($urandom_range(30, 100));
         resp_max   = int'($urandom_range(0, 3));
         stall_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_txn(mk(4'($urandom()), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, s),
                 mkc(int'($urandom_range(0, 6)), int'($urandom_range(0, 20))), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
